seq_ctrl_gen: RTL and testbench
===============================

# seq_ctrl_gen

Parametrised phase-sequencing controller, the next generation of the team's small fixed-encoding benchmark controllers. It steps a one-hot phase output through `N_PHASE` phases with a programmable dwell per phase, and supports single-pass, looping and single-step modes with hold and abort. It sits between the block-level start/abort handshake and the per-phase enables of the datapath it drives. All state is held in explicit registers so the block is usable as a scan-testable benchmark.

## Interface

Parameters:
- `N_PHASE`, 7, number of phases; legal range 2..32.
- `CNT_W`, 4, dwell counter width; each phase lasts dwell+1 cycles.
- `IDX_W`, `$clog2(N_PHASE)`, phase index width; derived, never overridden.

Ports:
- `CK` input 1: clock. All flops update on the falling edge of `CK`.
- `RST` input 1: reset, asynchronous, active-high.
- `start` input 1: begin a sequence from IDLE, or advance from STEP_WAIT.
- `abort` input 1: return to IDLE; has the highest functional priority.
- `hold` input 1: freezes the dwell counter and phase index while in RUN.
- `mode` input 2: 00 single pass, 01 loop, 10 single-step, 11 treated as 00.
- `dwell` input CNT_W: dwell value, latched on the accepted `start` from IDLE.
- `phase_out` output N_PHASE: one-hot active phase; all zero when not in RUN.
- `phase_idx` output IDX_W: current phase index.
- `busy` output 1: high in RUN and STEP_WAIT.
- `done` output 1: one-cycle pulse when a sequence completes normally.

## Operation

- States: IDLE, RUN, STEP_WAIT, DONE. Binary encoding, 2 bits.
- Reset values: state=IDLE, `phase_idx`=0, cnt=0, dwell_r=0, mode_r=00, `phase_out`=0, `busy`=0, `done`=0.
- IDLE, with `start`=1: latch `dwell` into dwell_r and `mode` into mode_r. Set idx=0 and cnt=`dwell`. Go to RUN.
- RUN: `phase_out`=1<<idx.
  - `hold`=1: cnt and idx are frozen.
  - cnt!=0: cnt decrements.
  - cnt==0 and idx<N_PHASE-1: idx increments and cnt reloads from dwell_r. If mode_r=10, go to STEP_WAIT.
  - cnt==0 and idx==N_PHASE-1:
    - mode_r=01: idx=0, cnt reloads, stay in RUN.
    - mode_r=10: go to STEP_WAIT with idx=0. Completion is signalled on that `start`.
    - otherwise: go to DONE.
- STEP_WAIT: `phase_out`=0 and `phase_idx` holds the next index. `start`=1 returns to RUN. In mode_r=10, a `start` issued after the last phase goes to DONE instead of RUN.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `abort`=1 in any state: go to IDLE on the next edge. Clear idx and cnt. `done` is not pulsed. `abort` overrides `start` and `hold` in the same cycle.
- `start` outside IDLE and STEP_WAIT is ignored. `mode` and `dwell` are only sampled on the accepted `start` from IDLE.
- `RST` asserted mid-sequence forces all reset values immediately, independent of `CK`.

## Timing

- All outputs are registered or decoded from registers only. There is no combinational input-to-output path.
- `start` sampled at falling edge k: `phase_out[0]` and `busy` are valid after edge k.
- Each phase lasts dwell_r+1 cycles, plus one cycle for every cycle `hold` is high.
- Single pass with no hold: RUN lasts N_PHASE×(dwell_r+1) cycles, `done` is high for the following cycle, and the block is in IDLE one cycle later.
- `abort` at edge k: IDLE outputs are valid after edge k.
- Loop mode never asserts `done`. It can only be left by `abort` or `RST`.

## Configuration

- `SEQ_CTRL_SCAN_EN` defined: adds ports `scan_en` (input, 1 bit), `scan_in` (input, 1 bit) and `scan_out` (output, 1 bit).
  - All state flops form one chain, in this order: state, idx, cnt, dwell_r, mode_r. `scan_in` feeds state[1]; `scan_out` is mode_r[0].
  - `scan_en`=1 shifts one bit per falling edge and suppresses functional updates.
  - `RST` still overrides `scan_en`.
- `SEQ_CTRL_SCAN_EN` undefined: the scan ports do not exist and the flops have no scan muxing.

## Test plan

- Reset, then N_PHASE=7, mode=00, dwell=2, one-cycle `start` → `phase_out` is 0000001 for 3 cycles, then 0000010 for 3 cycles, …, then 1000000 for 3 cycles. `done` is high on cycle 22 only, and `busy` is low from cycle 22.
- mode=01, dwell=0 → `phase_out` rotates through all 7 one-hot values every cycle and wraps 1000000→0000001. After 20 cycles, `abort` → `phase_out`=0 next cycle, and `done` never pulses.
- mode=10, dwell=1 → each phase lasts 2 cycles, then STEP_WAIT with `phase_out`=0 and `busy`=1. Seven `start` pulses visit phases 0..6. The eighth `start` produces the `done` pulse.
- mode=00, dwell=3, `hold`=1 for 5 cycles inside phase 2 → phase 2 lasts 9 cycles and total RUN lasts 33 cycles.
- `RST` pulsed asynchronously mid-phase 4 → all outputs zero before the next `CK` edge. `start` and `abort` high together in IDLE → the block stays in IDLE.
- With `SEQ_CTRL_SCAN_EN` defined: shift a pattern that loads state=RUN, idx=5, cnt=0, mode_r=00. Drop `scan_en` → the next edge gives `phase_out`=1000000, and the `done` pulse follows dwell_r+1 cycles later. Shifting a further 2+IDX_W+2·CNT_W+2 bits out of `scan_out` returns the loaded pattern.

Source files
------------

// File: rtl/seq_ctrl_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_ctrl_gen
// Purpose  : One-hot phase sequencer with a programmable dwell per phase.
//            Supports single-pass, loop and single-step modes, with hold and
//            abort. Every flop updates on the falling edge of CK. RST is
//            asynchronous and active-high.
// Options  : SEQ_CTRL_SCAN_EN adds a scan chain through all state flops.
//            Chain order is state, idx, cnt, dwell_r, mode_r.
// Revision : 1.0 - initial release
// ============================================================================
module seq_ctrl_gen #(
  parameter int N_PHASE = 7,
  parameter int CNT_W   = 4,
  parameter int IDX_W   = $clog2(N_PHASE)
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               start,
  input  logic               abort,
  input  logic               hold,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   dwell,
`ifdef SEQ_CTRL_SCAN_EN
  input  logic               scan_en,
  input  logic               scan_in,
  output logic               scan_out,
`endif
  output logic [N_PHASE-1:0] phase_out,
  output logic [IDX_W-1:0]   phase_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN       = 2'b01,
    STEP_WAIT = 2'b10,
    DONE      = 2'b11
  } state_t;

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_PHASE - 1);
  localparam logic [N_PHASE-1:0] ONE_HOT0 = N_PHASE'(1);
  localparam logic [1:0]         MODE_LOOP = 2'b01;
  localparam logic [1:0]         MODE_STEP = 2'b10;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] dwell_r, dwell_n;
  logic [1:0]       mode_r, mode_n;

  // Next-state and next-datapath decode; abort wins over everything else
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    dwell_n = dwell_r;
    mode_n  = mode_r;
    if (abort) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dwell_n = dwell;
            mode_n  = mode;
            idx_n   = '0;
            cnt_n   = dwell;
            state_n = RUN;
          end
        end
        RUN: begin
          if (!hold) begin
            if (cnt != '0) begin
              cnt_n = cnt - CNT_W'(1);
            end else if (idx != LAST_IDX) begin
              idx_n = idx + IDX_W'(1);
              cnt_n = dwell_r;
              if (mode_r == MODE_STEP) state_n = STEP_WAIT;
            end else begin
              case (mode_r)
                MODE_LOOP: begin
                  idx_n = '0;
                  cnt_n = dwell_r;
                end
                MODE_STEP: begin
                  idx_n   = '0;
                  cnt_n   = dwell_r;
                  state_n = STEP_WAIT;
                end
                default: state_n = DONE;
              endcase
            end
          end
        end
        STEP_WAIT: begin
          // Waiting with idx wrapped to 0 means the last phase has run, so
          // this start completes the sequence instead of resuming it.
          if (start) state_n = (idx == '0) ? DONE : RUN;
        end
        DONE: begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef SEQ_CTRL_SCAN_EN
  logic [1:0]       scan_state;
  logic [IDX_W-1:0] scan_idx;
  logic [CNT_W-1:0] scan_cnt;
  logic [CNT_W-1:0] scan_dwell;
  logic [1:0]       scan_mode;

  // Chain shifts toward mode_r[0]; scan_in enters at state[1]
  assign {scan_state, scan_idx, scan_cnt, scan_dwell, scan_mode} =
    {scan_in, state, idx, cnt, dwell_r, mode_r[1]};
  assign scan_out = mode_r[0];
`endif

  // State and datapath registers, falling-edge clocked with async reset
  always_ff @(negedge CK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      dwell_r <= '0;
      mode_r  <= 2'b00;
`ifdef SEQ_CTRL_SCAN_EN
    end else if (scan_en) begin
      state   <= state_t'(scan_state);
      idx     <= scan_idx;
      cnt     <= scan_cnt;
      dwell_r <= scan_dwell;
      mode_r  <= scan_mode;
`endif
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      dwell_r <= dwell_n;
      mode_r  <= mode_n;
    end
  end

  // Outputs are decoded from registers only
  assign phase_out = (state == RUN) ? (ONE_HOT0 << idx) : '0;
  assign phase_idx = idx;
  assign busy      = (state == RUN) || (state == STEP_WAIT);
  assign done      = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_ctrl_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_ctrl_gen
// Purpose  : Directed self-checking bench for seq_ctrl_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_ctrl_gen;

  localparam int N_PHASE = 7;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = 3;

  logic               CK    = 1'b1;
  logic               RST   = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               hold  = 1'b0;
  logic [1:0]         mode  = 2'b00;
  logic [CNT_W-1:0]   dwell = '0;
  logic [N_PHASE-1:0] phase_out;
  logic [IDX_W-1:0]   phase_idx;
  logic               busy;
  logic               done;
`ifdef SEQ_CTRL_SCAN_EN
  logic               scan_en = 1'b0;
  logic               scan_in = 1'b0;
  logic               scan_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  seq_ctrl_gen #(.N_PHASE(N_PHASE), .CNT_W(CNT_W)) dut (
    .CK        (CK),
    .RST       (RST),
    .start     (start),
    .abort     (abort),
    .hold      (hold),
    .mode      (mode),
    .dwell     (dwell),
`ifdef SEQ_CTRL_SCAN_EN
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .scan_out  (scan_out),
`endif
    .phase_out (phase_out),
    .phase_idx (phase_idx),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock; the DUT acts on falling edges
  always #5 CK = ~CK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance past the next active edge and settle
  task automatic step();
    @(negedge CK);
    #1;
  endtask

  // One-cycle start from IDLE; returns in the first RUN cycle
  task automatic kick(input logic [1:0] m, input logic [CNT_W-1:0] d);
    mode  = m;
    dwell = d;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [31:0] onehot(input int p);
    return 32'd1 << p;
  endfunction

`ifdef SEQ_CTRL_SCAN_EN
  localparam int CH_W = 2 + IDX_W + 2*CNT_W + 2;
`endif

  initial begin
    // ---------------- reset values ----------------
    #2;
    check_val("rst_phase_out", 32'(phase_out), 32'd0);
    check_val("rst_phase_idx", 32'(phase_idx), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    step();
    step();
    RST = 1'b0;
    step();

    // ---------------- single pass, dwell=2 ----------------
    // A stray start in cycle 5 must be ignored while running.
    kick(2'b00, 4'd2);
    for (int c = 1; c <= 23; c++) begin
      if (c <= 21) begin
        check_val("sp_phase", 32'(phase_out), onehot((c - 1) / 3));
        check_val("sp_busy", 32'(busy), 32'd1);
        check_val("sp_done", 32'(done), 32'd0);
      end else begin
        check_val("sp_end_phase", 32'(phase_out), 32'd0);
        check_val("sp_end_busy", 32'(busy), 32'd0);
        check_val("sp_end_done", 32'(done), (c == 22) ? 32'd1 : 32'd0);
      end
      start = (c == 5);
      step();
    end
    start = 1'b0;

    // ---------------- loop mode, dwell=0, then abort ----------------
    kick(2'b01, 4'd0);
    for (int c = 1; c <= 20; c++) begin
      check_val("loop_phase", 32'(phase_out), onehot((c - 1) % 7));
      check_val("loop_done", 32'(done), 32'd0);
      if (c == 20) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    check_val("abort_phase", 32'(phase_out), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_idx", 32'(phase_idx), 32'd0);
    step();
    check_val("abort_idle", 32'(busy), 32'd0);

    // ---------------- single-step mode, dwell=1 ----------------
    kick(2'b10, 4'd1);
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < 2; k++) begin
        check_val("step_phase", 32'(phase_out), onehot(p));
        check_val("step_busy", 32'(busy), 32'd1);
        step();
      end
      for (int k = 0; k < 2; k++) begin
        check_val("wait_phase", 32'(phase_out), 32'd0);
        check_val("wait_busy", 32'(busy), 32'd1);
        check_val("wait_idx", 32'(phase_idx), 32'((p + 1) % 7));
        check_val("wait_done", 32'(done), 32'd0);
        step();
      end
      start = 1'b1;
      step();
      start = 1'b0;
    end
    check_val("step_done", 32'(done), 32'd1);
    check_val("step_done_busy", 32'(busy), 32'd0);
    step();
    check_val("step_after_done", 32'(done), 32'd0);

    // ---------------- hold inside phase 2, dwell=3 ----------------
    kick(2'b00, 4'd3);
    for (int c = 1; c <= 35; c++) begin
      int exp_p;
      hold = (c >= 10 && c <= 14);
      if (c <= 8)       exp_p = (c - 1) / 4;
      else if (c <= 17) exp_p = 2;
      else              exp_p = 3 + (c - 18) / 4;
      if (c <= 33) begin
        check_val("hold_phase", 32'(phase_out), onehot(exp_p));
        check_val("hold_done", 32'(done), 32'd0);
      end else begin
        check_val("hold_end_phase", 32'(phase_out), 32'd0);
        check_val("hold_end_done", 32'(done), (c == 34) ? 32'd1 : 32'd0);
      end
      step();
    end
    hold = 1'b0;

    // ---------------- async reset mid phase 4 ----------------
    kick(2'b00, 4'd2);
    for (int c = 1; c < 14; c++) step();
    check_val("pre_rst_phase", 32'(phase_out), onehot(4));
    #2;
    RST = 1'b1;
    #1;
    check_val("arst_phase", 32'(phase_out), 32'd0);
    check_val("arst_idx", 32'(phase_idx), 32'd0);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_done", 32'(done), 32'd0);
    RST = 1'b0;
    step();

    // ---------------- start and abort together in IDLE ----------------
    mode  = 2'b00;
    dwell = 4'd1;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_val("sa_busy", 32'(busy), 32'd0);
    check_val("sa_phase", 32'(phase_out), 32'd0);
    step();
    check_val("sa_busy2", 32'(busy), 32'd0);

`ifdef SEQ_CTRL_SCAN_EN
    // ---------------- scan load, readback, functional release ----------------
    begin
      logic [CH_W-1:0] pat;
      logic [CH_W-1:0] got;
      pat = {2'b01, 3'd5, 4'd0, 4'd2, 2'b00};
      got = '0;
      scan_en = 1'b1;
      for (int i = 0; i < CH_W; i++) begin
        scan_in = pat[i];
        step();
      end
      for (int i = 0; i < CH_W; i++) begin
        got[i]  = scan_out;
        scan_in = pat[i];
        step();
      end
      check_val("scan_readback", 32'(got), 32'(pat));
      scan_en = 1'b0;
      check_val("scan_loaded_phase", 32'(phase_out), onehot(5));
      step();
      check_val("scan_phase6", 32'(phase_out), onehot(6));
      step();
      step();
      check_val("scan_pre_done", 32'(done), 32'd0);
      step();
      check_val("scan_done", 32'(done), 32'd1);
      step();
      check_val("scan_idle", 32'(busy), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
